uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/prim_util_pkg_u.sv | 9 +
 rtl/uart_arb_pkg.sv | 9 +
 rtl/uart_rr_pick.sv | 27 ++
 rtl/uart_tx_arb.sv | 87 ++++++++
 tb/tb_uart_tx_arb.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prim_util_pkg_u.sv
// Small utility package: width helpers shared across the arbiter slice.
package prim_util_pkg_u;

  // Bits needed to encode values 0..value-1, never less than one bit.
  function automatic integer vbits(integer value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter: FSM encoding.
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping N-1 -> 0.
module uart_rr_pick #(
  parameter int N    = 4,
  parameter int IdxW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  logic [IdxW-1:0] k;

  always_comb begin
    idx = '0;
    any = 1'b0;
    k   = ptr;
    for (int i = 0; i < N; i++) begin
      if (!any && req[k]) begin
        idx = k;
        any = 1'b1;
      end
      k = (k == IdxW'(N - 1)) ? '0 : k + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter: N byte requesters share one UART TX FIFO port.
// Valid/ready: a byte moves on a cycle where valid && ready; ready never waits on valid.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int MaxBurst = 16,
  localparam int IdxW    = prim_util_pkg_u::vbits(N),
  localparam int BurstW  = prim_util_pkg_u::vbits(MaxBurst + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_valid_i,
  input  logic [N*DW-1:0] req_data_i,
  input  logic [N-1:0]    req_last_i,
  output logic [N-1:0]    req_ready_o,
  output logic            tx_valid_o,
  output logic [DW-1:0]   tx_data_o,
  input  logic            tx_ready_i,
  output logic [IdxW-1:0] grant_idx_o,
  output logic            busy_o,
  output arb_state_e      state_o
);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   owner_q, rr_ptr_q, pick_idx, ptr_next;
  logic              pick_any;
  logic [BurstW-1:0] cnt_q, cnt_inc;
  logic              xfer, done;

  uart_rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_pick (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign cnt_inc  = cnt_q + 1'b1;
  assign ptr_next = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    xfer        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = LOCKED;
      end
      LOCKED: begin
        tx_valid_o           = req_valid_i[owner_q];
        tx_data_o            = req_data_i[owner_q*DW +: DW];
        req_ready_o[owner_q] = tx_ready_i;
        xfer                 = tx_valid_o && tx_ready_i;
        // last and burst limit collapse into one release condition
        done = xfer && (req_last_i[owner_q] || (cnt_inc == BurstW'(MaxBurst)));
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_any) owner_q <= pick_idx;
      if (xfer) cnt_q <= done ? '0 : cnt_inc;
      if (done) rr_ptr_q <= ptr_next;
    end
  end

  assign grant_idx_o = owner_q;
  assign busy_o      = (state_q == LOCKED);
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-requester byte sources, scoreboard queues and a packet-level arbitration model.
module tb_uart_tx_arb;
  import uart_arb_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MB   = 16;
  localparam int IdxW = 2;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_valid_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_last_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            tx_valid_o;
  logic [DW-1:0]   tx_data_o;
  logic            tx_ready_i = 1'b0;
  logic [IdxW-1:0] grant_idx_o;
  logic            busy_o;
  arb_state_e      dbg_state;

  uart_tx_arb #(.N(N), .DW(DW), .MaxBurst(MB)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_idx_o (grant_idx_o),
    .busy_o      (busy_o),
    .state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]    delay;
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  ent_t        src_q[N][$];
  logic [DW:0] exp_q[N][$];
  int          dut_grants[$];
  int          tests = 0;
  int          fails = 0;
  int          ready_mode = 1;
  bit          rnd_gaps = 1'b0;
  logic [N-1:0] acc = '0;

  // arbitration model: whole packets, ownership and round-robin pointer
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_cnt    = 0;
  bit prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += exp_q[k].size();
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_pkt(input int k, input int len, input int gap_at, input int gap_len);
    ent_t e;
    for (int i = 0; i < len; i++) begin
      e.data  = DW'($urandom_range(0, 255));
      e.last  = (i == len - 1);
      if (i == gap_at) e.delay = 8'(gap_len);
      else if (rnd_gaps && $urandom_range(0, 4) == 0) e.delay = 8'($urandom_range(1, 3));
      else e.delay = 8'd0;
      src_q[k].push_back(e);
      exp_q[k].push_back({e.last, e.data});
    end
  endtask

  // Called just after a rising edge.
  task automatic do_reset();
    #1;
    rst_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    dut_grants.delete();
  endtask

  task automatic wait_drain(input string name, input int bound);
    int c = 0;
    while (pending() != 0 && c < bound) begin
      @(posedge clk_i);
      c++;
    end
    check({"drain_", name}, 32'(pending()), 32'd0);
    repeat (3) @(posedge clk_i);
  endtask

  task automatic grant_at(input string name, input int i, input int e);
    int g;
    g = (i < dut_grants.size()) ? dut_grants[i] : -1;
    check(name, 32'(g), 32'(e));
  endtask

  // Input driver: retire accepted bytes, then present each source head.
  initial begin
    ent_t h;
    forever begin
      @(posedge clk_i);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && src_q[k].size() > 0) src_q[k].delete(0);
        req_valid_i[k] = 1'b0;
        req_last_i[k]  = 1'b0;
        req_data_i[k*DW +: DW] = DW'($urandom_range(0, 255));
        if (src_q[k].size() > 0) begin
          h = src_q[k][0];
          if (h.delay != 8'd0) begin
            h.delay = h.delay - 8'd1;
            src_q[k][0] = h;
          end else begin
            req_valid_i[k] = 1'b1;
            req_last_i[k]  = h.last;
            req_data_i[k*DW +: DW] = h.data;
          end
        end
      end
      case (ready_mode)
        0:       tx_ready_i = ($urandom_range(0, 3) != 0);
        2:       tx_ready_i = ~tx_ready_i;
        default: tx_ready_i = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [DW:0]  e;
    logic [N-1:0] er;
    int           k;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        check("reset_outputs", 32'({busy_o, tx_valid_o, req_ready_o, grant_idx_o, tx_data_o}), 32'd0);
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        acc = '0; prev_busy = 1'b0;
      end else begin
        acc = req_valid_i & req_ready_o;
        if (busy_o && !prev_busy) dut_grants.push_back(int'(grant_idx_o));
        prev_busy = busy_o;
        if (!m_locked) begin
          check("idle_outputs", 32'({busy_o, tx_valid_o, req_ready_o}), 32'd0);
          check("idle_grant_idx", 32'(grant_idx_o), 32'(m_owner));
          for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (req_valid_i[k]) begin
              m_owner = k; m_locked = 1'b1; m_cnt = 0;
              break;
            end
          end
        end else begin
          er = tx_ready_i ? (N'(1) << m_owner) : '0;
          check("busy", 32'(busy_o), 32'd1);
          check("grant_idx", 32'(grant_idx_o), 32'(m_owner));
          check("tx_valid", 32'(tx_valid_o), 32'(req_valid_i[m_owner]));
          check("req_ready", 32'(req_ready_o), 32'(er));
          if (req_valid_i[m_owner] && tx_ready_i) begin
            if (exp_q[m_owner].size() == 0) begin
              check("unexpected_byte", 32'(m_owner), 32'hffff_ffff);
              e = {req_last_i[m_owner], tx_data_o};
            end else begin
              e = exp_q[m_owner].pop_front();
              check("tx_data", 32'(tx_data_o), 32'(e[DW-1:0]));
            end
            m_cnt++;
            if (e[DW] || m_cnt == MB) begin
              m_locked = 1'b0;
              m_ptr = (m_owner + 1) % N;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    rst_i = 1'b1;
    ready_mode = 1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // lone requester 2, then pointer must sit at 3
    send_pkt(2, 3, -1, 0);
    wait_drain("req2_alone", 200);
    grant_at("req2_grant", 0, 2);
    send_pkt(0, 1, -1, 0);
    send_pkt(3, 1, -1, 0);
    wait_drain("ptr_after_req2", 200);
    grant_at("ptr3_first", 1, 3);
    grant_at("ptr3_second", 2, 0);

    // all requesters continuously valid with 1-byte packets
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) send_pkt(k, 1, -1, 0);
    wait_drain("rr_all", 300);
    for (int i = 0; i < 5; i++) grant_at("rr_order", i, i % N);

    // burst limit: 20 bytes from 1 split at 16, 2 served in between
    do_reset();
    send_pkt(1, 20, -1, 0);
    send_pkt(2, 2, -1, 0);
    wait_drain("burst", 400);
    grant_at("burst_g0", 0, 1);
    grant_at("burst_g1", 1, 2);
    grant_at("burst_g2", 2, 1);

    // last coinciding with the 16th byte releases once
    do_reset();
    send_pkt(0, 16, -1, 0);
    send_pkt(1, 1, -1, 0);
    wait_drain("last_at_max", 400);
    grant_at("coincide_g0", 0, 0);
    grant_at("coincide_g1", 1, 1);
    check("coincide_count", 32'(dut_grants.size()), 32'd2);

    // tx_ready toggling during owner 3 packet
    do_reset();
    ready_mode = 2;
    send_pkt(3, 4, -1, 0);
    wait_drain("ready_toggle", 200);
    grant_at("toggle_g0", 0, 3);
    ready_mode = 1;

    // reset after byte 2 of a 5-byte packet
    do_reset();
    send_pkt(1, 5, -1, 0);
    c = 0;
    while (exp_q[1].size() != 3 && c < 200) begin
      @(posedge clk_i);
      c++;
    end
    check("wait_byte2", 32'(exp_q[1].size()), 32'd3);
    do_reset();
    send_pkt(0, 1, -1, 0);
    send_pkt(1, 1, -1, 0);
    wait_drain("after_reset", 200);
    grant_at("post_reset_g0", 0, 0);
    grant_at("post_reset_g1", 1, 1);

    // owner 0 stalls 10 cycles mid-packet while 1 waits
    do_reset();
    send_pkt(0, 4, 1, 10);
    send_pkt(1, 2, -1, 0);
    wait_drain("stall", 300);
    grant_at("stall_g0", 0, 0);
    grant_at("stall_g1", 1, 1);
    check("stall_grants", 32'(dut_grants.size()), 32'd2);

    // randomized traffic
    do_reset();
    ready_mode = 0;
    rnd_gaps = 1'b1;
    for (int p = 0; p < 200; p++) begin
      send_pkt($urandom_range(0, N - 1), $urandom_range(1, 20), -1, 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(posedge clk_i);
    end
    wait_drain("random", 40000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
